// File: rtl/stepper_pulse_gen.sv
// Step/direction pulse generator for one stepper axis, driven by a 24-bit PIO command word.
// GO is a toggle: a command is pending whenever cmd_word[23] differs from the last accepted GO.
module stepper_pulse_gen #(
    parameter int BASE_DIV    = 500,
    parameter int PULSE_WIDTH = 50,
    parameter int DIR_SETUP   = 250
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] cmd_word,
    output logic        step,
    output logic        dir,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] steps_remaining
);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    localparam int PH_MAX = (DIR_SETUP > PULSE_WIDTH) ? DIR_SETUP : PULSE_WIDTH;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int DIV_W  = $clog2(BASE_DIV + 1);

    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(DIR_SETUP - 1);
    localparam logic [PH_W-1:0]  PULSE_LAST = PH_W'(PULSE_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BASE_DIV - 1);

    state_t            state, state_next;
    logic              go_q, go_next;
    logic [4:0]        rate_q, rate_next;
    logic [PH_W-1:0]   phase_cnt, phase_next;
    logic [DIV_W-1:0]  presc, presc_next;
    logic [4:0]        ticks, ticks_next;
    logic              abort_seen, abort_seen_next;
    logic              step_next, dir_next, busy_next, done_next, aborted_next;
    logic [15:0]       sr_next;

    logic              pending;
    logic              abort_in;
    logic              period_end;

    assign pending    = cmd_word[23] != go_q;
    assign abort_in   = cmd_word[21];
    assign period_end = (presc == DIV_LAST) && (ticks == rate_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            go_q            <= 1'b0;
            rate_q          <= '0;
            phase_cnt       <= '0;
            presc           <= '0;
            ticks           <= '0;
            abort_seen      <= 1'b0;
            step            <= 1'b0;
            dir             <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            steps_remaining <= '0;
        end else begin
            state           <= state_next;
            go_q            <= go_next;
            rate_q          <= rate_next;
            phase_cnt       <= phase_next;
            presc           <= presc_next;
            ticks           <= ticks_next;
            abort_seen      <= abort_seen_next;
            step            <= step_next;
            dir             <= dir_next;
            busy            <= busy_next;
            done            <= done_next;
            aborted         <= aborted_next;
            steps_remaining <= sr_next;
        end
    end

    // The step period is timed from each rise: a BASE_DIV prescaler feeding an R+1 tick counter.
    always_comb begin
        state_next      = state;
        go_next         = go_q;
        rate_next       = rate_q;
        phase_next      = phase_cnt;
        presc_next      = presc;
        ticks_next      = ticks;
        abort_seen_next = abort_seen;
        step_next       = step;
        dir_next        = dir;
        busy_next       = busy;
        done_next       = 1'b0;
        aborted_next    = aborted;
        sr_next         = steps_remaining;

        if (state == HIGH || state == LOW) begin
            if (presc == DIV_LAST) begin
                presc_next = '0;
                ticks_next = ticks + 1'b1;
            end else begin
                presc_next = presc + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (pending && !abort_in) begin
                    go_next      = cmd_word[23];
                    rate_next    = cmd_word[20:16];
                    sr_next      = cmd_word[15:0];
                    aborted_next = 1'b0;
                    if (cmd_word[15:0] == 16'd0) begin
                        done_next = 1'b1;
                    end else begin
                        dir_next   = cmd_word[22];
                        busy_next  = 1'b1;
                        phase_next = '0;
                        state_next = SETUP;
                    end
                end
            end
            SETUP: begin
                if (abort_in) begin
                    state_next   = IDLE;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    aborted_next = 1'b1;
                end else if (phase_cnt == SETUP_LAST) begin
                    state_next      = HIGH;
                    step_next       = 1'b1;
                    phase_next      = '0;
                    presc_next      = '0;
                    ticks_next      = '0;
                    abort_seen_next = 1'b0;
                end else begin
                    phase_next = phase_cnt + 1'b1;
                end
            end
            HIGH: begin
                abort_seen_next = abort_seen | abort_in;
                if (phase_cnt == PULSE_LAST) begin
                    step_next = 1'b0;
                    sr_next   = steps_remaining - 16'd1;
                    if (abort_seen || abort_in) begin
                        state_next   = IDLE;
                        busy_next    = 1'b0;
                        done_next    = 1'b1;
                        aborted_next = 1'b1;
                    end else begin
                        state_next = LOW;
                    end
                end else begin
                    phase_next = phase_cnt + 1'b1;
                end
            end
            LOW: begin
                if (abort_in) begin
                    state_next   = IDLE;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    aborted_next = 1'b1;
                end else if (period_end) begin
                    if (steps_remaining == 16'd0) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next      = HIGH;
                        step_next       = 1'b1;
                        phase_next      = '0;
                        presc_next      = '0;
                        ticks_next      = '0;
                        abort_seen_next = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Self-checking bench for stepper_pulse_gen: expected step rises and done pulses are queued
// with their cycle numbers when a command is driven, and matched as the DUT produces them.
module tb_stepper_pulse_gen;

    localparam int BD = 10;
    localparam int PW = 3;
    localparam int DS = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] cmd_word = '0;
    logic        step, dir, busy, done, aborted;
    logic [15:0] steps_remaining;

    typedef struct {
        int   kind;
        int   cyc;
        logic dir;
        logic aborted;
        int   sr;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rise_count = 0;
    int   done_count = 0;
    int   rise_cyc = 0;
    logic step_prev = 1'b0;
    logic go_bit = 1'b0;

    stepper_pulse_gen #(
        .BASE_DIV(BD),
        .PULSE_WIDTH(PW),
        .DIR_SETUP(DS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_word(cmd_word),
        .step(step),
        .dir(dir),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .steps_remaining(steps_remaining)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every step rise and done pulse is popped against the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (!reset_n) begin
            step_prev = 1'b0;
        end else begin
            if (step && !step_prev) begin
                rise_count++;
                rise_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_step rise at cycle %0d, none required", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind !== 0 || e.cyc !== cyc || dir !== e.dir) begin
                        errors++;
                        $display("[TB] FAIL step_rise got cycle %0d dir %b, required kind %0d cycle %0d dir %b",
                                 cyc, dir, e.kind, e.cyc, e.dir);
                    end
                end
            end
            if (!step && step_prev) begin
                checks++;
                if (cyc - rise_cyc !== PW) begin
                    errors++;
                    $display("[TB] FAIL pulse_width got %0d, required %0d", cyc - rise_cyc, PW);
                end
            end
            if (done) begin
                done_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_done at cycle %0d, none required", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind !== 1 || e.cyc !== cyc || busy !== 1'b0 ||
                        aborted !== e.aborted || steps_remaining !== 16'(e.sr)) begin
                        errors++;
                        $display("[TB] FAIL done_event got cycle %0d busy %b aborted %b sr %0d, required kind %0d cycle %0d busy 0 aborted %b sr %0d",
                                 cyc, busy, aborted, steps_remaining, e.kind, e.cyc, e.aborted, e.sr);
                    end
                end
            end
            step_prev = step;
        end
    end

    function automatic logic [23:0] mk_cmd(input logic go, input logic d, input logic ab,
                                           input int r, input int n);
        return {go, d, ab, 5'(r), 16'(n)};
    endfunction

    task automatic goto_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_rise(input int c, input logic d);
        ev_t e;
        e.kind = 0; e.cyc = c; e.dir = d; e.aborted = 1'b0; e.sr = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int c, input logic ab, input int sr);
        ev_t e;
        e.kind = 1; e.cyc = c; e.dir = 1'b0; e.aborted = ab; e.sr = sr;
        exp_q.push_back(e);
    endtask

    // Model of a complete move accepted (busy rising) at cycle a; returns its done cycle.
    task automatic push_move(input int a, input int n, input int r, input logic d,
                             output int done_cyc);
        int p;
        p = BD * (r + 1);
        for (int k = 0; k < n; k++) push_rise(a + DS + k * p, d);
        done_cyc = a + DS + n * p;
        push_done(done_cyc, 1'b0, 0);
    endtask

    task automatic toggle_go(input logic d, input int r, input int n);
        go_bit = ~go_bit;
        cmd_word = mk_cmd(go_bit, d, 1'b0, r, n);
    endtask

    task automatic drain(input string name, input int budget);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            @(posedge clk);
            #1;
            b++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain got %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        int r0, d0;
        reset_n = 1'b0;
        cmd_word = '0;
        go_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({step, dir, busy, done, aborted} !== 5'b0 || steps_remaining !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got step %b dir %b busy %b done %b aborted %b sr %0d, required all 0",
                     step, dir, busy, done, aborted, steps_remaining);
        end
        reset_n = 1'b1;
        r0 = rise_count;
        d0 = done_count;
        goto_cycle(cyc + 100);
        checks++;
        if (rise_count !== r0 || done_count !== d0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_quiet got rises %0d dones %0d busy %b, required 0 0 0",
                     rise_count - r0, done_count - d0, busy);
        end
    endtask

    task automatic test_basic_move;
        int a, dc;
        toggle_go(1'b1, 1, 3);
        a = cyc + 1;
        push_move(a, 3, 1, 1'b1, dc);
        goto_cycle(a);
        checks++;
        if (busy !== 1'b1 || dir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL move_start got busy %b dir %b, required 1 1", busy, dir);
        end
        drain("basic_move", 200);
        goto_cycle(dc + 1);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL move_end got busy %b done %b, required 0 0", busy, done);
        end
    endtask

    task automatic test_zero_steps;
        int a;
        toggle_go(1'b0, 2, 0);
        a = cyc + 1;
        push_done(a, 1'b0, 0);
        goto_cycle(a);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_steps got done %b busy %b dir %b, required 1 0 1", done, busy, dir);
        end
        drain("zero_steps", 20);
        goto_cycle(cyc + 20);
    endtask

    task automatic test_abort;
        int a, r0;
        toggle_go(1'b1, 0, 5);
        a = cyc + 1;
        push_rise(a + DS, 1'b1);
        push_rise(a + DS + BD, 1'b1);
        push_done(a + DS + BD + PW, 1'b1, 3);
        goto_cycle(a + DS + BD + 1);
        cmd_word[21] = 1'b1;
        goto_cycle(a + DS + BD + PW + 2);
        cmd_word[21] = 1'b0;
        drain("abort", 20);
        r0 = rise_count;
        goto_cycle(cyc + 60);
        checks++;
        if (rise_count !== r0 || busy !== 1'b0 || aborted !== 1'b1 || steps_remaining !== 16'd3) begin
            errors++;
            $display("[TB] FAIL abort_after got extra rises %0d busy %b aborted %b sr %0d, required 0 0 1 3",
                     rise_count - r0, busy, aborted, steps_remaining);
        end
    endtask

    task automatic test_back_to_back;
        int a1, a2, d1, d2;
        toggle_go(1'b1, 0, 2);
        a1 = cyc + 1;
        push_move(a1, 2, 0, 1'b1, d1);
        a2 = d1 + 1;
        push_move(a2, 1, 0, 1'b0, d2);
        goto_cycle(a1);
        checks++;
        if (aborted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL aborted_clear got %b, required 0", aborted);
        end
        goto_cycle(a1 + 8);
        toggle_go(1'b0, 0, 1);
        goto_cycle(a2);
        checks++;
        if (busy !== 1'b1 || dir !== 1'b0) begin
            errors++;
            $display("[TB] FAIL queued_accept got busy %b dir %b, required 1 0", busy, dir);
        end
        drain("back_to_back", 200);
        goto_cycle(d2 + 1);
    endtask

    task automatic test_reset_mid_pulse;
        int a, r0, dc;
        toggle_go(1'b1, 0, 3);
        a = cyc + 1;
        push_rise(a + DS, 1'b1);
        goto_cycle(a + DS + 1);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (step !== 1'b0 || busy !== 1'b0 || dir !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got step %b busy %b dir %b, required 0 0 0", step, busy, dir);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_first_rise got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        cmd_word = '0;
        go_bit = 1'b0;
        goto_cycle(cyc + 2);
        reset_n = 1'b1;
        r0 = rise_count;
        goto_cycle(cyc + 30);
        checks++;
        if (rise_count !== r0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_quiet got rises %0d busy %b, required 0 0", rise_count - r0, busy);
        end
        toggle_go(1'b1, 1, 2);
        a = cyc + 1;
        push_move(a, 2, 1, 1'b1, dc);
        drain("post_reset_move", 200);
        goto_cycle(dc + 2);
    endtask

    initial begin
        test_reset;
        test_basic_move;
        test_zero_steps;
        test_abort;
        test_back_to_back;
        test_reset_mid_pulse;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
